// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, redirect, IF/ID reg.
// Ports: clk/rst, imem_*, stall/jump/jr/branch_taken/jr_target, ins/ins_pc4/ins_valid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        jr,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] ins,
  output logic [31:0] ins_pc4,
  output logic        ins_valid
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic [31:0] r_ins_pc4;
  logic        r_ins_valid;
  logic [31:0] r_buf;
  logic [31:0] r_pending;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_target;
  logic        w_redir;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_ins[15]}}, r_ins[15:0], 2'b00};

  // Only a real, accepted instruction in decode may redirect.
  assign w_redir = r_ins_valid & ~stall
                 & (jr | jump | branch_taken);

  always_comb begin
    w_target = r_ins_pc4 + w_br_off;
    if (jr)
      w_target = jr_target & 32'hFFFF_FFFC;
    else if (jump)
      w_target = {r_ins_pc4[31:28], r_ins[25:0], 2'b00};
  end

  assign imem_req  = ((r_state == S_FETCH) || (r_state == S_DROP)) && !rst;
  assign imem_addr = r_pc;
  assign ins       = r_ins;
  assign ins_pc4   = r_ins_pc4;
  assign ins_valid = r_ins_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ins       <= 32'h0;
      r_ins_pc4   <= 32'h0;
      r_ins_valid <= 1'b0;
      r_buf       <= 32'h0;
      r_pending   <= 32'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_redir) begin
            r_ins       <= 32'h0;
            r_ins_valid <= 1'b0;
            if (imem_ack) begin
              r_pc <= w_target;
            end else begin
              // Request is already on the bus: let it finish, drop its data.
              r_pending <= w_target;
              r_state   <= S_DROP;
            end
          end else if (imem_ack) begin
            r_pc <= w_pc4;
            if (stall) begin
              r_buf   <= imem_rdata;
              r_state <= S_FULL;
            end else begin
              r_ins       <= imem_rdata;
              r_ins_pc4   <= w_pc4;
              r_ins_valid <= 1'b1;
            end
          end else if (!stall) begin
            r_ins       <= 32'h0;
            r_ins_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (!stall) begin
            r_state <= S_FETCH;
            if (w_redir) begin
              r_pc        <= w_target;
              r_ins       <= 32'h0;
              r_ins_valid <= 1'b0;
            end else begin
              // pc already advanced past the parked word.
              r_ins       <= r_buf;
              r_ins_pc4   <= r_pc;
              r_ins_valid <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!stall) begin
            r_ins       <= 32'h0;
            r_ins_valid <= 1'b0;
          end
          if (imem_ack) begin
            r_pc    <= r_pending;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// stall/redirect/ack-delay run against a program-order reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump;
  logic        jr;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic [31:0] ins;
  logic [31:0] ins_pc4;
  logic        ins_valid;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem_ovr [logic [31:0]];
  int mem_cnt = 0;
  int mem_max = 0;
  bit mem_rand = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .jump(jump), .jr(jr),
    .branch_taken(branch_taken), .jr_target(jr_target),
    .ins(ins), .ins_pc4(ins_pc4), .ins_valid(ins_valid)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a | 32'h2000_0000;
  endfunction

  // Memory: answers a request after mem_cnt idle cycles.
  task automatic mem_step();
    if (imem_req) begin
      if (mem_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = rd(imem_addr);
        mem_cnt = mem_rand ? int'($urandom_range(0, mem_max)) : mem_max;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt--;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mem_step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0; jump = 1'b0; jr = 1'b0; branch_taken = 1'b0;
    jr_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    mem_max = 0; mem_cnt = 0; mem_rand = 1'b0;
    step();
    step();
    n_checks++; if (ins !== 32'h0) begin n_fail++; $display("FAIL rst_ins got %h want 0", ins); end
    n_checks++; if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ins_valid); end
    n_checks++; if (ins_pc4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4 got %h want 0", ins_pc4); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
    rst = 1'b0;
    #1;
    mem_step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_req got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (ins !== rd(32'(4 * i))) begin n_fail++; $display("FAIL zw_ins%0d got %h want %h", i, ins, rd(32'(4 * i))); end
      n_checks++; if (ins_pc4 !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL zw_pc4%0d got %h want %h", i, ins_pc4, 4 * i + 4); end
      n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid%0d got %b want 1", i, ins_valid); end
    end
  endtask

  task automatic test_stall_full();
    stall = 1'b1;
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL full_addr got %h want 8", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req%0d got %b want 0", i, imem_req); end
      n_checks++; if (ins !== rd(32'h4)) begin n_fail++; $display("FAIL full_hold%0d got %h want %h", i, ins, rd(32'h4)); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (ins !== rd(32'h8) || ins_pc4 !== 32'hC) begin n_fail++; $display("FAIL full_release got %h/%h want %h/c", ins, ins_pc4, rd(32'h8)); end
    n_checks++; if (imem_addr !== 32'hC) begin n_fail++; $display("FAIL full_resume got %h want c", imem_addr); end
    step();
    n_checks++; if (ins !== rd(32'hC) || ins_pc4 !== 32'h10 || ins_valid !== 1'b1) begin n_fail++; $display("FAIL full_next got %h/%h want %h/10", ins, ins_pc4, rd(32'hC)); end
  endtask

  task automatic test_jump();
    jump = 1'b1;
    step();
    jump = 1'b0;
    n_checks++; if (ins !== 32'h0 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL j_bubble got %h/%b want 0/0", ins, ins_valid); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL j_addr got %h want 100", imem_addr); end
    step();
    n_checks++; if (ins !== rd(32'h100) || ins_pc4 !== 32'h104) begin n_fail++; $display("FAIL j_target got %h/%h want %h/104", ins, ins_pc4, rd(32'h100)); end
  endtask

  task automatic test_branch();
    jump = 1'b1;
    step();
    jump = 1'b0;
    step();
    n_checks++; if (ins !== 32'h1000_FFFE || ins_pc4 !== 32'h20) begin n_fail++; $display("FAIL br_setup got %h/%h want 1000fffe/20", ins, ins_pc4); end
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h18 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL br_addr got %h/%b want 18/0", imem_addr, ins_valid); end
    step();
    n_checks++; if (ins !== rd(32'h18) || ins_pc4 !== 32'h1C) begin n_fail++; $display("FAIL br_target got %h/%h want %h/1c", ins, ins_pc4, rd(32'h18)); end
  endtask

  task automatic test_jr();
    jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
    jr_target = 32'h3D;
    step();
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 32'h3C || ins_valid !== 1'b0) begin n_fail++; $display("FAIL jr_addr got %h/%b want 3c/0", imem_addr, ins_valid); end
    step();
    n_checks++; if (ins !== rd(32'h3C) || ins_pc4 !== 32'h40) begin n_fail++; $display("FAIL jr_target got %h/%h want %h/40", ins, ins_pc4, rd(32'h3C)); end
  endtask

  task automatic test_drop();
    int k;
    mem_max = 2; mem_cnt = 2;
    step();
    n_checks++; if (ins !== rd(32'h40) || ins_pc4 !== 32'h44) begin n_fail++; $display("FAIL drop_pre got %h/%h want %h/44", ins, ins_pc4, rd(32'h40)); end
    jr = 1'b1; jr_target = 32'h200;
    step();
    jr = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin n_fail++; $display("FAIL drop_hold got %b/%h want 1/44", imem_req, imem_addr); end
    n_checks++; if (ins !== 32'h0 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL drop_bubble got %h/%b want 0/0", ins, ins_valid); end
    step();
    n_checks++; if (imem_addr !== 32'h44 || ins !== 32'h0) begin n_fail++; $display("FAIL drop_ack got %h/%h want 44/0", imem_addr, ins); end
    step();
    n_checks++; if (imem_addr !== 32'h200 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL drop_redir got %h/%b want 200/0", imem_addr, ins_valid); end
    k = 0;
    while (!ins_valid && k < 10) begin
      n_checks++; if (ins !== 32'h0) begin n_fail++; $display("FAIL drop_leak got %h want 0", ins); end
      step();
      k++;
    end
    n_checks++; if (ins_valid !== 1'b1) begin n_fail++; $display("FAIL drop_timeout got %b want 1", ins_valid); end
    n_checks++; if (ins !== rd(32'h200) || ins_pc4 !== 32'h204) begin n_fail++; $display("FAIL drop_target got %h/%h want %h/204", ins, ins_pc4, rd(32'h200)); end
  endtask

  task automatic test_rst_full();
    int k;
    stall = 1'b1;
    k = 0;
    while (imem_req && k < 10) begin step(); k++; end
    n_checks++; if (imem_req !== 1'b0 || ins !== rd(32'h200)) begin n_fail++; $display("FAIL rf_full got %b/%h want 0/%h", imem_req, ins, rd(32'h200)); end
    rst = 1'b1;
    step();
    n_checks++; if (ins !== 32'h0 || ins_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_reset got %h/%b/%b want 0/0/0", ins, ins_valid, imem_req); end
    mem_max = 3; mem_cnt = 3;
    stall = 1'b0;
    rst = 1'b0;
    #1;
    mem_step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rf_restart got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_rst_drop();
    int k;
    k = 0;
    while (!ins_valid && k < 10) begin step(); k++; end
    n_checks++; if (ins_valid !== 1'b1 || ins !== rd(32'h0)) begin n_fail++; $display("FAIL rd_pre got %b/%h want 1/%h", ins_valid, ins, rd(32'h0)); end
    jump = 1'b1;
    step();
    jump = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ins_valid !== 1'b0) begin n_fail++; $display("FAIL rd_drop got %b/%h/%b want 1/4/0", imem_req, imem_addr, ins_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_mask got %b want 0", imem_req); end
    step();
    n_checks++; if (ins !== 32'h0 || ins_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_reset got %h/%b/%b want 0/0/0", ins, ins_valid, imem_req); end
    mem_max = 0; mem_cnt = 0;
    rst = 1'b0;
    #1;
    mem_step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rd_restart got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    step();
    jr = 1'b1; jr_target = 32'hFFFF_FFFE;
    step();
    jr = 1'b0;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
    step();
    n_checks++; if (ins !== rd(32'hFFFF_FFFC) || ins_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_top got %h/%h want %h/0", ins, ins_pc4, rd(32'hFFFF_FFFC)); end
    step();
    n_checks++; if (ins !== rd(32'h0) || ins_pc4 !== 32'h4) begin n_fail++; $display("FAIL wrap_zero got %h/%h want %h/4", ins, ins_pc4, rd(32'h0)); end
  endtask

  // Reference: the instruction decode sees next must be the one at exp_pc
  // in program order; bubbles may appear anywhere.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] pc4;
    logic [31:0] im;
    logic [31:0] a;
    logic [31:0] prev_addr;
    bit prev_pend;
    int r;
    exp_pc = 32'h0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    mem_rand = 1'b1; mem_max = 2;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (ins_valid) begin
        n_checks++; if (ins !== rd(exp_pc) || ins_pc4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL rnd_ins cyc %0d got %h/%h want %h/%h", cyc, ins, ins_pc4, rd(exp_pc), exp_pc + 32'd4); end
      end else begin
        n_checks++; if (ins !== 32'h0) begin n_fail++; $display("FAIL rnd_bubble cyc %0d got %h want 0", cyc, ins); end
      end
      a = imem_addr;
      n_checks++; if (a[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_align cyc %0d got %h", cyc, a); end
      if (prev_pend && imem_req) begin
        n_checks++; if (imem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_stable cyc %0d got %h want %h", cyc, imem_addr, prev_addr); end
      end
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      stall = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 9));
      jr = (r == 0 || r == 3);
      jump = (r == 1 || r == 3);
      branch_taken = (r == 2 || r == 3);
      jr_target = ($urandom_range(0, 7) == 0) ? ($urandom | 32'hFFFF_FF00)
                                                : ($urandom & 32'h0000_FFFF);
      if (ins_valid && !stall) begin
        im = rd(exp_pc);
        pc4 = exp_pc + 32'd4;
        if (jr)
          exp_pc = jr_target & 32'hFFFF_FFFC;
        else if (jump)
          exp_pc = (pc4 & 32'hF000_0000) + ((im & 32'h03FF_FFFF) * 32'd4);
        else if (branch_taken)
          exp_pc = pc4 + 32'(int'($signed(im[15:0])) * 4);
        else
          exp_pc = pc4;
      end
      step();
    end
    stall = 1'b0; jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    mem_ovr[32'h0000_000C] = 32'h0800_0040;
    mem_ovr[32'h0000_0100] = 32'h0800_0007;
    mem_ovr[32'h0000_001C] = 32'h1000_FFFE;
    test_reset();
    test_zero_wait();
    test_stall_full();
    test_jump();
    test_branch();
    test_jr();
    test_drop();
    test_rst_full();
    test_rst_drop();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder/controller.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Redirects on jump, jr and taken branch; the redirect comes from the instruction currently in decode.
- Owns the IF/ID register whose `ins` output drives the decoder. A bubble is presented as 32'h0 (nop).

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request. Held high with imem_addr stable until imem_ack.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_ack  in  1  read data valid this cycle. May be asserted in the same cycle as imem_req.
- imem_rdata  in  32  instruction word; sampled only when imem_ack=1.
- stall  in  1  decode cannot accept; IF/ID holds its contents.
- jump  in  1  j/jal in decode.
- jr  in  1  jr in decode.
- branch_taken  in  1  conditional branch in decode resolved taken.
- jr_target  in  32  rs value for jr.
- ins  out  32  IF/ID instruction to the decoder; 0 when not valid.
- ins_pc4  out  32  PC+4 of `ins`.
- ins_valid  out  1  `ins` is a real fetched instruction.

Behaviour:

Reset:
- rst=1 at an edge sets pc=RESET_PC, state=FETCH, ins=0, ins_pc4=0, ins_valid=0, buffer cleared.
- imem_req is forced 0 while rst=1. An outstanding request is abandoned; the memory shares rst.

Handshake and state:
- imem_req = (state==FETCH || state==DROP) && !rst.
- imem_addr = pc in all states.

States:
- FETCH (request outstanding)
- FULL (fetched word parked in a one-entry buffer because decode stalled)
- DROP (request outstanding whose data is to be discarded)

Redirect (sampled only when ins_valid=1 and stall=0; ignored otherwise):
- Priority is jr > jump > branch_taken.
- jr target: jr_target & ~3.
- jump target: {ins_pc4[31:28], ins[25:0], 2'b00}.
- branch target: ins_pc4 + ({{14{ins[15]}}, ins[15:0], 2'b00}), computed modulo 2^32.
- A redirect loads IF/ID with a bubble (ins=0, ins_valid=0). No delay slot is executed.

Transitions (a redirect is only possible when stall=0):

FETCH, ack=1:
- redirect: discard rdata; pc<=target; stay FETCH.
- stall=0, no redirect: ins<=rdata, ins_pc4<=pc+4, ins_valid<=1, pc<=pc+4; stay FETCH. This gives 1 instruction/cycle with a zero-wait memory.
- stall=1: buffer<=rdata; pc<=pc+4; go to FULL.

FETCH, ack=0:
- redirect: pending<=target; go to DROP.
- stall=0, no redirect: IF/ID <= bubble.
- stall=1: IF/ID holds.

FULL (imem_req=0):
- stall=1: hold.
- stall=0, redirect: discard buffer; pc<=target; go to FETCH.
- stall=0, no redirect: IF/ID <= buffer, with ins_pc4 = pc (already advanced); go to FETCH.

DROP:
- Every cycle with stall=0 loads a bubble into IF/ID.
- On ack: discard rdata; pc<=pending; go to FETCH.

Arithmetic: pc+4 wraps from 32'hFFFF_FFFC to 0.

Latency: a redirect in decode at edge N puts the target's first request on the bus in cycle N+1 (FETCH/FULL), or in the cycle after the discarded ack (DROP).

Test Plan:
- Reset then zero-wait memory (ack tied to req, rdata=addr|32'h2000_0000) → ins sequence 32'h2000_0000, 32'h2000_0004, … on consecutive cycles; ins_pc4=4, 8, …; ins_valid=1 from the 2nd post-reset edge.
- stall=1 for 3 cycles while ack=1 at pc=8 → state FULL, imem_req=0, ins holds; after stall drops, ins=word@8, ins_pc4=12, then fetch resumes at 12 with no lost or duplicated word.
- Decode holds j with ins[25:0]=26'h40, ins_pc4=32'h0000_0010 → pc=32'h0000_0100, one bubble (ins=0), next valid ins from addr 0x100.
- Taken branch with ins[15:0]=16'hFFFE, ins_pc4=32'h20 → next fetch address 32'h18. jr with jump also asserted and jr_target=32'h3D → fetch address 32'h3C (jr wins, low bits cleared).
- Redirect while ack delayed 2 cycles → state DROP, imem_addr stays at the old pc until ack; the old word never reaches ins; the next request goes to the target.
- rst asserted during a FULL stall and again during DROP → the next cycle shows ins=0, ins_valid=0, imem_req=0; the first request after release is at RESET_PC.
